branch_resolve_pipe: RTL and testbench

BRANCH_RESOLVE_PIPE -- requirements
Module: branch_resolve_pipe

---
 rtl/branch_resolve_if.sv | 29 ++
 rtl/branch_resolve_pipe.sv | 70 +++++++
 tb/tb_branch_resolve_pipe.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// E-to-M branch resolution bus: E-stage compare inputs, M-stage redirect/flush
// outputs and retired-branch statistics.
interface branch_resolve_if #(
    parameter int CNT_W = 32
);
    logic             BranchE;
    logic             BranchNeE;
    logic [31:0]      SrcAE;
    logic [31:0]      SrcBE;
    logic [31:0]      PCBranchE;
    logic             StallM;
    logic             PCSrcM;
    logic [31:0]      PCBranchM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic [CNT_W-1:0] BranchCnt;
    logic [CNT_W-1:0] TakenCnt;

    modport master (
        output BranchE, BranchNeE, SrcAE, SrcBE, PCBranchE, StallM,
        input  PCSrcM, PCBranchM, FlushD, FlushE, FlushM, BranchCnt, TakenCnt
    );

    modport slave (
        input  BranchE, BranchNeE, SrcAE, SrcBE, PCBranchE, StallM,
        output PCSrcM, PCBranchM, FlushD, FlushE, FlushM, BranchCnt, TakenCnt
    );
endinterface

// File: rtl/branch_resolve_pipe.sv
// Resolves beq/bne in E, registers the outcome into M, and redirects fetch and
// flushes the younger stages when a taken branch leaves M; keeps saturating stats.
module branch_resolve_pipe #(
    parameter int CNT_W      = 32,
    parameter int ENABLE_BNE = 1
) (
    input logic              clk,
    input logic              rst_n,
    branch_resolve_if.slave  bus
);
    localparam logic             BNE_ON  = (ENABLE_BNE != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             eq_e;
    logic             bne_e;
    logic             is_br_e;
    logic             taken_e;
    logic             is_br_m;
    logic             taken_m;
    logic             pc_src_m;
    logic [31:0]      pc_branch_m;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    assign eq_e    = (bus.SrcAE == bus.SrcBE);
    assign bne_e   = bus.BranchNeE & BNE_ON;
    assign is_br_e = bus.BranchE | bne_e;
    assign taken_e = (bus.BranchE & eq_e) | (bne_e & ~eq_e);

    // A stalled taken branch waits in M and redirects on its first free cycle.
    assign pc_src_m = taken_m & ~bus.StallM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_br_m     <= 1'b0;
            taken_m     <= 1'b0;
            pc_branch_m <= 32'h0000_0000;
        end else if (!bus.StallM) begin
            if (pc_src_m) begin
                // Instruction in E is on the wrong path; target is kept for visibility.
                is_br_m <= 1'b0;
                taken_m <= 1'b0;
            end else begin
                is_br_m     <= is_br_e;
                taken_m     <= taken_e;
                pc_branch_m <= bus.PCBranchE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            if (is_br_m && !bus.StallM && branch_cnt != CNT_MAX)
                branch_cnt <= branch_cnt + 1'b1;
            if (pc_src_m && taken_cnt != CNT_MAX)
                taken_cnt <= taken_cnt + 1'b1;
        end
    end

    assign bus.PCSrcM    = pc_src_m;
    assign bus.PCBranchM = pc_branch_m;
    assign bus.FlushD    = pc_src_m;
    assign bus.FlushE    = pc_src_m;
    assign bus.FlushM    = pc_src_m;
    assign bus.BranchCnt = branch_cnt;
    assign bus.TakenCnt  = taken_cnt;
endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Bench for branch_resolve_pipe: 32-bit and 4-bit counter instances share stimulus.
module tb_branch_resolve_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_i = 1'b0, bne_i = 1'b0, stall_i = 1'b0;
    logic [31:0] a_i = '0, b_i = '0, tgt_i = '0;

    always #5 clk = ~clk;

    branch_resolve_if #(.CNT_W(32)) b32 ();
    branch_resolve_if #(.CNT_W(4))  b4 ();

    assign b32.BranchE = br_i;   assign b4.BranchE = br_i;
    assign b32.BranchNeE = bne_i; assign b4.BranchNeE = bne_i;
    assign b32.SrcAE = a_i;      assign b4.SrcAE = a_i;
    assign b32.SrcBE = b_i;      assign b4.SrcBE = b_i;
    assign b32.PCBranchE = tgt_i; assign b4.PCBranchE = tgt_i;
    assign b32.StallM = stall_i; assign b4.StallM = stall_i;

    branch_resolve_pipe #(.CNT_W(32), .ENABLE_BNE(1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    branch_resolve_pipe #(.CNT_W(4),  .ENABLE_BNE(1)) dut4  (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

    // Reference: the branch sitting in M plus unbounded retire tallies.
    bit              m_isbr, m_taken;
    logic [31:0]     m_tgt;
    longint unsigned bcnt, tcnt;
    int              checks = 0, failures = 0;

    typedef struct {
        logic        br, bne;
        logic [31:0] a, b, tgt;
        logic        exp_taken, exp_isbr;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic longint unsigned sat4(input longint unsigned v);
        return (v > 15) ? 64'd15 : v;
    endfunction

    task automatic check_model();
        logic exp_red;
        exp_red = m_taken & ~stall_i & rst_n;
        chk("pcsrc",    64'(b32.PCSrcM), 64'(exp_red));
        chk("flushd",   64'(b32.FlushD), 64'(exp_red));
        chk("flushe",   64'(b32.FlushE), 64'(exp_red));
        chk("flushm",   64'(b32.FlushM), 64'(exp_red));
        chk("pcbranch", 64'(b32.PCBranchM), 64'(m_tgt));
        chk("bcnt32",   64'(b32.BranchCnt), bcnt);
        chk("tcnt32",   64'(b32.TakenCnt), tcnt);
        chk("pcsrc4",   64'(b4.PCSrcM), 64'(exp_red));
        chk("bcnt4",    64'(b4.BranchCnt), sat4(bcnt));
        chk("tcnt4",    64'(b4.TakenCnt), sat4(tcnt));
    endtask

    task automatic model_reset();
        m_isbr = 0; m_taken = 0; m_tgt = '0; bcnt = 0; tcnt = 0;
    endtask

    task automatic model_edge();
        bit eq, isbr, tk, redirect;
        eq       = (a_i == b_i);
        isbr     = br_i | bne_i;
        tk       = (br_i & eq) | (bne_i & ~eq);
        redirect = m_taken && !stall_i;
        if (m_isbr && !stall_i) bcnt++;
        if (redirect) tcnt++;
        if (!stall_i) begin
            if (redirect) begin
                m_isbr = 0; m_taken = 0;
            end else begin
                m_isbr = isbr; m_taken = tk; m_tgt = tgt_i;
            end
        end
    endtask

    task automatic drive(input logic br, input logic bne, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] tgt, input logic stall);
        br_i = br; bne_i = bne; a_i = a; b_i = b; tgt_i = tgt; stall_i = stall;
        #1;
        check_model();
    endtask

    task automatic idle(input logic stall);
        drive(1'b0, 1'b0, 32'h0, 32'h1, 32'h0, stall);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        longint unsigned exp_b, exp_t;
        vecs[0] = '{1'b1, 1'b0, 32'h5,         32'h5,         32'h0001_0040, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 32'h5,         32'h6,         32'h0000_1111, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 32'h7,         32'h7,         32'h0000_2222, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 32'h7,         32'h8,         32'h0000_2000, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 32'h1,         32'h1,         32'h0000_3000, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 32'h1,         32'h2,         32'h0000_4000, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'h3,         32'h3,         32'h0000_5000, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hDEAD_BEE0, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         32'h0000_6000, 1'b0, 1'b1};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        chk("rst_pcsrc", 64'(b32.PCSrcM), 64'd0);
        chk("rst_pcbr",  64'(b32.PCBranchM), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Single-cycle E-stage vectors, each followed by an idle cycle.
        exp_b = 0; exp_t = 0;
        foreach (vecs[i]) begin
            drive(vecs[i].br, vecs[i].bne, vecs[i].a, vecs[i].b, vecs[i].tgt, 1'b0);
            tick();
            idle(1'b0);
            chk($sformatf("vec%0d_pcsrc", i), 64'(b32.PCSrcM), 64'(vecs[i].exp_taken));
            chk($sformatf("vec%0d_flushd", i), 64'(b32.FlushD), 64'(vecs[i].exp_taken));
            chk($sformatf("vec%0d_pcbr", i), 64'(b32.PCBranchM), 64'(vecs[i].tgt));
            tick();
            exp_b += 64'(vecs[i].exp_isbr);
            exp_t += 64'(vecs[i].exp_taken);
            idle(1'b0);
            chk($sformatf("vec%0d_bcnt", i), 64'(b32.BranchCnt), exp_b);
            chk($sformatf("vec%0d_tcnt", i), 64'(b32.TakenCnt), exp_t);
            tick();
        end

        // Back-to-back taken branches: second one is squashed.
        do_reset();
        drive(1'b1, 1'b0, 32'h9, 32'h9, 32'h0001_0040, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h9, 32'h9, 32'h0001_0080, 1'b0);
        chk("b2b_first", 64'(b32.PCSrcM), 64'd1);
        tick();
        idle(1'b0);
        chk("b2b_second", 64'(b32.PCSrcM), 64'd0);
        chk("b2b_pcbr",   64'(b32.PCBranchM), 64'h0001_0040);
        tick();
        idle(1'b0);
        chk("b2b_bcnt", 64'(b32.BranchCnt), 64'd1);
        chk("b2b_tcnt", 64'(b32.TakenCnt), 64'd1);
        tick();

        // Taken branch held in M by a 3-cycle stall.
        do_reset();
        drive(1'b1, 1'b0, 32'h2, 32'h2, 32'h0000_0A00, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 32'h2, 32'h2, 32'h0000_0B00, 1'b1);
            chk($sformatf("stall%0d_pcsrc", k), 64'(b32.PCSrcM), 64'd0);
            chk($sformatf("stall%0d_bcnt", k), 64'(b32.BranchCnt), 64'd0);
            tick();
        end
        idle(1'b0);
        chk("stall_release", 64'(b32.PCSrcM), 64'd1);
        chk("stall_pcbr", 64'(b32.PCBranchM), 64'h0000_0A00);
        tick();
        idle(1'b0);
        chk("stall_once", 64'(b32.PCSrcM), 64'd0);
        chk("stall_tcnt", 64'(b32.TakenCnt), 64'd1);
        tick();

        // Saturation of the 4-bit counters.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 1'b0, 32'h4, 32'h4, 32'h100 + 32'(k), 1'b0);
            tick();
            idle(1'b0);
            tick();
        end
        idle(1'b0);
        chk("sat_bcnt4",  64'(b4.BranchCnt), 64'hF);
        chk("sat_tcnt4",  64'(b4.TakenCnt), 64'hF);
        chk("sat_bcnt32", 64'(b32.BranchCnt), 64'd17);
        tick();

        // Reset mid-operation with a taken branch in M.
        drive(1'b1, 1'b0, 32'h3, 32'h3, 32'h0000_0C00, 1'b0);
        tick();
        idle(1'b0);
        chk("pre_rst_pcsrc", 64'(b32.PCSrcM), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pcsrc", 64'(b32.PCSrcM), 64'd0);
        chk("mid_rst_flush", 64'(b32.FlushM), 64'd0);
        chk("mid_rst_pcbr",  64'(b32.PCBranchM), 64'd0);
        chk("mid_rst_bcnt",  64'(b32.BranchCnt), 64'd0);
        chk("mid_rst_tcnt4", 64'(b4.TakenCnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        idle(1'b0);
        chk("post_rst_pcsrc", 64'(b32.PCSrcM), 64'd0);
        tick();

        // Randomized traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] ra, rb;
            ra = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 3));
            rb = $urandom_range(0, 1) == 0 ? ra : 32'($urandom_range(0, 3));
            drive(1'($urandom), 1'($urandom), ra, rb, $urandom, $urandom_range(0, 3) == 0);
            tick();
        end
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
